// File: rtl/delay_pkg.sv
// Shared constants and helpers for the delay timer and its round-robin arbiter.
package delay_pkg;

  localparam int N_DEFAULT     = 12500;
  localparam int CBITS_DEFAULT = 14;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // First set request scanning ptr, ptr+1, ... modulo nreq (nreq <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int nreq);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % nreq;
      if (i < nreq && !found && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/delay_rr_arb.sv
// Round-robin winner selection with its rotating priority pointer register.
module delay_rr_arb
  import delay_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PBITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             ptr_load,
  input  logic [PBITS-1:0] ptr_next,
  output logic [PBITS-1:0] winner,
  output logic             any_req
);

  logic [PBITS-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst)           ptr <= '0;
    else if (ptr_load) ptr <= ptr_next;
  end

  assign winner  = PBITS'(rr_pick(8'(req), 3'(ptr), NREQ));
  assign any_req = |req;

endmodule

// File: rtl/delay_slot_arbiter.sv
// Shares one delay counter among NREQ requesters; the owner holds it until expiry or abort.
module delay_slot_arbiter
  import delay_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int N     = N_DEFAULT,
  parameter int CBITS = CBITS_DEFAULT,
  parameter int PBITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [PBITS-1:0] owner,
  output logic [CBITS-1:0] cnt_o,
  output logic             err
);

  // state  | meaning
  // IDLE   | no owner; arbitrate among pending requests
  // COUNT  | owner holds the timer, cnt runs 0..N-1
  // DONE   | one-cycle done pulse to owner, then release

  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(N - 1);
  localparam logic [CBITS-1:0] CNT_MAX  = CBITS'(N);

  logic [1:0]       state;
  logic [CBITS-1:0] cnt;
  logic [PBITS-1:0] winner;
  logic [PBITS-1:0] owner_inc;
  logic             any_req;
  logic             ptr_load;
  logic [NREQ-1:0]  winner_oh;
  logic [NREQ-1:0]  owner_oh;

  assign owner_inc = (owner == PBITS'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign winner_oh = {{(NREQ-1){1'b0}}, 1'b1} << winner;
  assign owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner;

  // The pointer advances past the owner whenever a grant ends, by abort or expiry.
  assign ptr_load = (state == ST_DONE) || (state == ST_COUNT && !req[owner]);

  delay_rr_arb #(.NREQ(NREQ), .PBITS(PBITS)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ptr_load (ptr_load),
    .ptr_next (owner_inc),
    .winner   (winner),
    .any_req  (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      owner <= '0;
      err   <= 1'b0;
    end else begin
      if (cnt > CNT_MAX) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          done <= '0;
          if (any_req) begin
            state <= ST_COUNT;
            grant <= winner_oh;
            owner <= winner;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_COUNT: begin
          // Abort takes priority over expiry in the same cycle.
          if (!req[owner]) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_DONE;
            done  <= owner_oh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          grant <= '0;
          done  <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          done  <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign cnt_o = cnt;

endmodule

// File: tb/tb_delay_slot_arbiter.sv
// Directed and randomized checks of delay_slot_arbiter with N=5, NREQ=4.
module tb_delay_slot_arbiter;

  localparam int NREQ  = 4;
  localparam int N     = 5;
  localparam int CBITS = 14;
  localparam int PBITS = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic             busy;
  logic [PBITS-1:0] owner;
  logic [CBITS-1:0] cnt_o;
  logic             err;

  int compared   = 0;
  int mismatched = 0;

  delay_slot_arbiter #(.NREQ(NREQ), .N(N), .CBITS(CBITS), .PBITS(PBITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .owner (owner),
    .cnt_o (cnt_o),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic b, input logic [1:0] o, input int c);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_done"},  32'(done),  32'(d));
    chk({tag, "_busy"},  32'(busy),  32'(b));
    chk({tag, "_owner"}, 32'(owner), 32'(o));
    chk({tag, "_cnt"},   32'(cnt_o), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] exp_g;

    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 0);
    chk("reset_err", 32'(err), 32'd0);

    // single requester 2: grant next cycle, done after N count cycles
    req = 4'b0100;
    tick();
    chk_out("t1_start", 4'b0100, 4'b0000, 1'b1, 2'd2, 0);
    for (int k = 1; k < N; k++) begin
      tick();
      chk_out("t1_count", 4'b0100, 4'b0000, 1'b1, 2'd2, k);
    end
    tick();
    chk_out("t1_doneph", 4'b0100, 4'b0100, 1'b1, 2'd2, N - 1);
    req = 4'b0000;
    tick();
    chk_out("t1_idle", 4'b0000, 4'b0000, 1'b0, 2'd2, 0);

    // all requesting: rotation 0,1,2,3,0 with one idle cycle between grants
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      tick();
      chk_out("t2_start", exp_g, 4'b0000, 1'b1, 2'(g % 4), 0);
      for (int k = 1; k < N; k++) begin
        tick();
        chk("t2_count_done", 32'(done), 32'd0);
      end
      tick();
      chk_out("t2_doneph", exp_g, exp_g, 1'b1, 2'(g % 4), N - 1);
      tick();
      chk_out("t2_gap", 4'b0000, 4'b0000, 1'b0, 2'(g % 4), 0);
    end

    // abort by owner 1 at cnt==2; pointer moves to 2 so 3 beats 0
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b0010;
    tick();
    chk_out("t3_start", 4'b0010, 4'b0000, 1'b1, 2'd1, 0);
    req = 4'b1010;
    tick();
    tick();
    chk("t3_cnt2", 32'(cnt_o), 32'd2);
    req = 4'b1001;
    tick();
    chk_out("t3_abort", 4'b0000, 4'b0000, 1'b0, 2'd1, 0);
    tick();
    chk_out("t3_next", 4'b1000, 4'b0000, 1'b1, 2'd3, 0);

    // reset in the middle of a count
    tick();
    tick();
    tick();
    chk("t4_cnt3", 32'(cnt_o), 32'd3);
    rst = 1'b1;
    tick();
    chk_out("t4_reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 0);
    rst = 1'b0;
    tick();
    chk_out("t4_regrant", 4'b0001, 4'b0000, 1'b1, 2'd0, 0);

    // owner drops exactly on the last count cycle: abort beats expiry
    for (int k = 1; k < N; k++) tick();
    chk_out("t5_last", 4'b0001, 4'b0000, 1'b1, 2'd0, N - 1);
    req = 4'b1000;
    tick();
    chk_out("t5_abort", 4'b0000, 4'b0000, 1'b0, 2'd0, 0);
    tick();
    chk_out("t5_next", 4'b1000, 4'b0000, 1'b1, 2'd3, 0);

    // random request traffic with invariant checks
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
      req = r;
      tick();
      chk("rnd_onehot", 32'($onehot0(grant)), 32'd1);
      chk("rnd_done_in_grant", 32'(done & ~grant), 32'd0);
      chk("rnd_busy", 32'(busy), 32'(grant != 4'b0000));
      chk("rnd_cnt_range", 32'(cnt_o < CBITS'(N)), 32'd1);
    end
    chk("rnd_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/delay_slot_arbiter.md
Name: delay_slot_arbiter

Overview:
- Shares one programmable-length delay counter (N-cycle timer) between NREQ requesters.
- Arbitration is round-robin.
- The granted requester owns the timer until it expires; it then receives a one-cycle done pulse.
- Sits between client blocks needing fixed timeouts (debounce, watchdog windows) and the single shared counter resource. Duplicating the 14-bit counter per client is avoided.

Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 12500, delay length in cycles spent in COUNT per grant
- CBITS, 14, counter width; must satisfy 2**CBITS > N
- PBITS, 2, width of requester index; $clog2(NREQ)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester level request; held high until done or abandoned
- grant  output  NREQ  one-hot owner of the timer; all zero when idle
- done  output  NREQ  one-cycle pulse to owner at expiry
- busy  output  1  high while a grant is active (COUNT or DONE)
- owner  output  PBITS  index of current/last owner
- cnt_o  output  CBITS  current counter value, for debug
- err  output  1  sticky; counter exceeded N (invariant violation)

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; cnt=0; ptr=0; grant=0; done=0; busy=0; owner=0; err=0. Reset wins over every other event, including mid-COUNT; no done pulse is issued for the aborted grant.
- All outputs are registered.
- State IDLE:
  - If req != 0, winner = first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - Next state COUNT; grant=onehot(winner); owner=winner; cnt=0; busy=1.
  - If req == 0, stay in IDLE.
- State COUNT:
  - cnt increments by 1 each cycle.
  - When cnt == N-1, next state DONE. COUNT therefore lasts exactly N cycles (cnt values 0..N-1).
  - Abort: if req[owner]==0 in any COUNT cycle, next state IDLE; grant=0; busy=0; no done pulse; ptr=owner+1 mod NREQ.
- State DONE:
  - done[owner]=1 for exactly this cycle; grant held this cycle.
  - Next state IDLE; grant=0; busy=0; cnt=0; ptr=owner+1 mod NREQ.
- Latency: req sampled high in IDLE at cycle t gives grant at t+1 and done at t+N+1. The earliest next grant is at t+N+3 (one IDLE cycle between grants).
- Requests from non-owners during COUNT/DONE are ignored; they are evaluated in the next IDLE.
- Owner keeping req high after done: treated as a new request in IDLE, but ptr has moved past it, so other pending requesters win first.
- Fairness: a continuously held request is granted within NREQ-1 complete grants of others, i.e. wait <= (NREQ-1)*(N+2)+1 cycles.
- Simultaneous events:
  - Abort and expiry in the same cycle (req[owner]=0 while cnt==N-1): abort wins; no done.
- Width/counter rules:
  - cnt compares unsigned at CBITS; cnt never wraps in normal operation.
  - If cnt > N is ever observed, err sets and stays set until rst.
- Invariants:
  - grant is one-hot or zero.
  - done is a subset of grant.
  - busy == (grant != 0).
  - At most one done bit set per cycle.

Decomposition:
- Shared package delay_pkg holds:
  - state enum {IDLE, COUNT, DONE}
  - default N/CBITS constants, shared with the existing delay timer
  - function rr_pick(req, ptr) returning the winner index
- One sub-module: delay_rr_arb, the combinational round-robin winner selection with a ptr register interface. The FSM, counter and err logic stay in the top.

Test Plan (N=5, NREQ=4):
- Single req[2] held from cycle 1 -> grant=4'b0100 at cycle 2; done[2] pulse at cycle 7 only; grant=0 and busy=0 at cycle 8.
- req=4'b1111 held continuously after reset -> grant order 0,1,2,3,0; each grant lasts 6 cycles followed by 1 idle cycle; exactly one done per grant.
- req[1] dropped at cnt==2 while owner=1 -> next cycle grant=0, no done; pending req[3] granted on the following cycle; ptr=2.
- rst asserted mid-COUNT (cnt==3) -> next cycle all outputs zero and ptr=0; no done; req[0] then wins the next arbitration.
- req[owner] dropped exactly at cnt==N-1 -> no done pulse; state returns to IDLE.
- Full random run of 10k cycles with assertions (one-hot grant, done within grant, err never set) -> all pass, err==0.
